// File: rtl/stopwatch_scan_core.sv
// stopwatch_scan_core: NDIG-digit BCD stopwatch (mm:ss groups) with lap freeze, sticky overflow and a multiplexed 7-seg scan
// Ports: CLK, RST (async, active-high); btn_start/btn_clear/btn_lap raw button levels;
//        seg {g..a} and dig_n (active-low one-hot) registered scan outputs; running, lap_active,
//        overflow status; count_bcd live count, digit i at [4i+3:4i].
// Option: define LEADING_ZERO_BLANK_EN to blank leading-zero digits from index 2 upward.
module stopwatch_scan_core #(
  parameter int NDIG = 4,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              btn_start,
  input  logic              btn_clear,
  input  logic              btn_lap,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   dig_n,
  output logic              running,
  output logic              lap_active,
  output logic              overflow,
  output logic [4*NDIG-1:0] count_bcd
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  logic [2:0] sync_start, sync_clear, sync_lap;
  logic p_start, p_clear, p_lap, tick, blank;
  logic [TW-1:0] tdiv;
  logic [SW-1:0] sdiv;
  logic [IW-1:0] idx;
  logic [NDIG:0] carry;
  logic [4*NDIG-1:0] lap_reg, disp;
  logic [3:0] cur;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h00;
    endcase
  endfunction
  // two synchroniser stages, third stage holds the previous level for edge detection
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync_start <= '0;
      sync_clear <= '0;
      sync_lap <= '0;
    end else begin
      sync_start <= {sync_start[1:0], btn_start};
      sync_clear <= {sync_clear[1:0], btn_clear};
      sync_lap <= {sync_lap[1:0], btn_lap};
    end
  assign p_start = sync_start[1] & ~sync_start[2];
  assign p_clear = sync_clear[1] & ~sync_clear[2];
  assign p_lap = sync_lap[1] & ~sync_lap[2];
  assign tick = running && tdiv == TW'(TICK_DIV - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) tdiv <= '0;
    else if (p_clear || tick) tdiv <= '0;
    else if (running) tdiv <= tdiv + TW'(1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      running <= 1'b0;
      lap_active <= 1'b0;
      overflow <= 1'b0;
      lap_reg <= '0;
    end else if (p_clear) begin
      running <= 1'b0;
      lap_active <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (p_start) running <= ~running;
      if (p_lap) lap_active <= ~lap_active;
      if (p_lap && !lap_active) lap_reg <= count_bcd;
      if (carry[NDIG]) overflow <= 1'b1;
    end
  // carry[i] is the tick qualified by every lower digit sitting at its maximum
  assign carry[0] = tick;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [3:0] MX = (i % 2 == 0) ? 4'd9 : 4'd5;
    logic [3:0] d;
    assign carry[i+1] = carry[i] && d == MX;
    assign count_bcd[4*i +: 4] = d;
    always_ff @(posedge CLK or posedge RST)
      if (RST) d <= '0;
      else if (p_clear) d <= '0;
      else if (carry[i]) d <= d == MX ? 4'd0 : d + 4'd1;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sdiv <= '0;
      idx <= '0;
    end else begin
      sdiv <= sdiv == SW'(SCAN_DIV - 1) ? '0 : sdiv + SW'(1);
      if (sdiv == SW'(SCAN_DIV - 1)) idx <= idx == IW'(NDIG - 1) ? '0 : idx + IW'(1);
    end
  assign disp = lap_active ? lap_reg : count_bcd;
  assign cur = disp[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  // lz[i]: digit i and everything above it display zero; digits 0 and 1 never qualify
  logic [NDIG:0] lz;
  assign lz[NDIG] = 1'b1;
  for (genvar i = 0; i < NDIG; i++) begin : g_lz
    if (i < 2) begin : g_keep
      assign lz[i] = 1'b0;
    end else begin : g_chain
      assign lz[i] = lz[i+1] && disp[4*i +: 4] == 4'd0;
    end
  end
  assign blank = lz[idx];
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      seg <= '0;
      dig_n <= '1;
    end else begin
      seg <= blank ? 7'h00 : dec(cur);
      dig_n <= ~(NDIG'(1) << idx);
    end
endmodule

// File: tb/tb_stopwatch_scan_core.sv
// tb_stopwatch_scan_core: directed vector table, scan/lap corner sequences and randomized buttons against a reference model
module tb_stopwatch_scan_core;
  localparam int NDIG = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int TOTAL = 3600;
  localparam logic [6:0] SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic CLK = 1'b0, RST = 1'b1, btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic [6:0] seg;
  logic [NDIG-1:0] dig_n;
  logic running, lap_active, overflow;
  logic [4*NDIG-1:0] count_bcd;
  int total = 0, bad = 0;
  stopwatch_scan_core #(.NDIG(NDIG), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .RST(RST), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .seg(seg), .dig_n(dig_n), .running(running), .lap_active(lap_active),
    .overflow(overflow), .count_bcd(count_bcd)
  );
  always #5 CLK = ~CLK;
  function automatic int modv(int i);
    return (i % 2 != 0) ? 6 : 10;
  endfunction
  function automatic int wgt(int i);
    int w = 1;
    for (int k = 0; k < i; k++) w *= modv(k);
    return w;
  endfunction
  function automatic logic [15:0] enc(int v);
    logic [15:0] r;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % modv(i));
      v = v / modv(i);
    end
    return r;
  endfunction
  int n = 0, phase = 0, lap_n = 0, sc = 0;
  bit run = 0, lap_on = 0, ovf = 0, chk_en = 0;
  bit [2:0] hs = 0, hc = 0, hl = 0;
  logic [6:0] m_seg = 7'h00;
  logic [3:0] m_dig = 4'hF;
  task automatic model_reset();
    n = 0; phase = 0; lap_n = 0; sc = 0;
    run = 0; lap_on = 0; ovf = 0;
    hs = 0; hc = 0; hl = 0;
    m_seg = 7'h00; m_dig = 4'hF;
  endtask
  task automatic model_clk();
    int idx, dv, n0, shown;
    bit ps, pc, pl, tk;
    idx = sc / SCAN_DIV;
    shown = lap_on ? lap_n : n;
    dv = (shown / wgt(idx)) % modv(idx);
    m_seg = SEGS[dv];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx >= 2 && shown < wgt(idx)) m_seg = 7'h00;
`endif
    m_dig = ~(4'b0001 << idx);
    sc = (sc + 1) % (SCAN_DIV * NDIG);
    ps = hs[1] & ~hs[2];
    pc = hc[1] & ~hc[2];
    pl = hl[1] & ~hl[2];
    tk = run && phase == TICK_DIV - 1;
    n0 = n;
    if (pc) begin
      run = 0; lap_on = 0; ovf = 0; n = 0; phase = 0;
    end else begin
      if (tk) begin
        phase = 0;
        n = n + 1;
        if (n == TOTAL) begin
          n = 0;
          ovf = 1;
        end
      end else if (run) phase = phase + 1;
      if (ps) run = !run;
      if (pl) begin
        if (!lap_on) lap_n = n0;
        lap_on = !lap_on;
      end
    end
    hs = {hs[1:0], btn_start};
    hc = {hc[1:0], btn_clear};
    hl = {hl[1:0], btn_lap};
  endtask
  always @(posedge CLK or posedge RST)
    if (RST) model_reset();
    else model_clk();
  always @(negedge CLK)
    if (chk_en && !RST) begin
      total++;
      if ({count_bcd, running, lap_active, overflow, seg, dig_n} !== {enc(n), run, lap_on, ovf, m_seg, m_dig}) begin
        bad++;
        $display("FAIL model t=%0t: count=%h run=%b lap=%b ovf=%b seg=%h dig_n=%b, expected count=%h run=%b lap=%b ovf=%b seg=%h dig_n=%b",
                 $time, count_bcd, running, lap_active, overflow, seg, dig_n, enc(n), run, lap_on, ovf, m_seg, m_dig);
      end
    end
  task automatic tick(input int c);
    repeat (c) @(posedge CLK);
    #1;
  endtask
  task automatic press(input bit [2:0] m);
    if (m == 3'b000) return;
    btn_start = m[2]; btn_clear = m[1]; btn_lap = m[0];
    tick(3);
    btn_start = 0; btn_clear = 0; btn_lap = 0;
    tick(1);
  endtask
  task automatic check_slot(input int s, input logic [6:0] exp, input string nm);
    logic [3:0] want;
    bit hit;
    want = ~(4'b0001 << s);
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge CLK);
      #1;
      if (dig_n == want) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: slot %0d never enabled, dig_n=%b", nm, s, dig_n);
    end else if (seg !== exp) begin
      bad++;
      $display("FAIL %s: slot %0d seg=%h expected %h", nm, s, seg, exp);
    end
  endtask
  typedef struct {
    bit rst;
    bit [2:0] btn;
    int wait_n;
    logic [15:0] cnt;
    bit run, lap, ovf;
    int slot;
    logic [6:0] sg;
  } vec_t;
  vec_t vt [19];
  initial begin
    vt[0]  = '{0, 3'b000, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    vt[1]  = '{0, 3'b100, 239,   16'h0100, 1, 0, 0, -1, 7'h00};
    vt[2]  = '{0, 3'b000, 2160,  16'h1000, 1, 0, 0, -1, 7'h00};
    vt[3]  = '{0, 3'b010, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    vt[4]  = '{0, 3'b100, 14399, 16'h0000, 1, 0, 1, -1, 7'h00};
    vt[5]  = '{0, 3'b000, 4,     16'h0001, 1, 0, 1, -1, 7'h00};
    vt[6]  = '{0, 3'b010, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    vt[7]  = '{0, 3'b100, 19,    16'h0005, 1, 0, 0, -1, 7'h00};
    vt[8]  = '{0, 3'b001, 36,    16'h0015, 1, 1, 0, -1, 7'h00};
    vt[9]  = '{0, 3'b100, 0,     16'h0015, 0, 1, 0, 0,  7'h6D};
    vt[10] = '{0, 3'b001, 0,     16'h0015, 0, 0, 0, 0,  7'h6D};
    vt[11] = '{0, 3'b000, 0,     16'h0015, 0, 0, 0, 1,  7'h06};
    vt[12] = '{0, 3'b010, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    vt[13] = '{0, 3'b100, 167,   16'h0042, 1, 0, 0, -1, 7'h00};
    vt[14] = '{0, 3'b110, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    vt[15] = '{0, 3'b101, 0,     16'h0000, 1, 1, 0, -1, 7'h00};
    vt[16] = '{0, 3'b010, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    vt[17] = '{0, 3'b100, 147,   16'h0037, 1, 0, 0, -1, 7'h00};
    vt[18] = '{1, 3'b000, 0,     16'h0000, 0, 0, 0, -1, 7'h00};
    #12 RST = 1'b0;
    chk_en = 1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 19; i++) begin
      if (vt[i].rst) begin
        RST = 1'b1;
        #2;
        total++;
        if (seg !== 7'h00 || dig_n !== 4'hF) begin
          bad++;
          $display("FAIL reset outputs: seg=%h dig_n=%b expected seg=00 dig_n=1111", seg, dig_n);
        end
      end else begin
        press(vt[i].btn);
        tick(vt[i].wait_n);
      end
      total++;
      if ({count_bcd, running, lap_active, overflow} !== {vt[i].cnt, vt[i].run, vt[i].lap, vt[i].ovf}) begin
        bad++;
        $display("FAIL vec%0d: count=%h run=%b lap=%b ovf=%b, expected count=%h run=%b lap=%b ovf=%b",
                 i, count_bcd, running, lap_active, overflow, vt[i].cnt, vt[i].run, vt[i].lap, vt[i].ovf);
      end
      if (vt[i].rst) RST = 1'b0;
      if (vt[i].slot >= 0) check_slot(vt[i].slot, vt[i].sg, $sformatf("vec%0d_slot", i));
    end
    for (int k = 0; k < 10; k++) begin
      logic [3:0] want;
      @(posedge CLK);
      #1;
      want = ~(4'b0001 << ((k / SCAN_DIV) % NDIG));
      total++;
      if (dig_n !== want) begin
        bad++;
        $display("FAIL scan%0d: dig_n=%b expected %b", k, dig_n, want);
      end
    end
    press(3'b100);
    tick(25);
    press(3'b100);
    total++;
    if ({count_bcd, running} !== {16'h0007, 1'b0}) begin
      bad++;
      $display("FAIL hold7: count=%h run=%b expected count=0007 run=0", count_bcd, running);
    end
    check_slot(0, 7'h07, "d0_of_7");
    check_slot(1, 7'h3F, "d1_of_7");
`ifdef LEADING_ZERO_BLANK_EN
    check_slot(2, 7'h00, "d2_of_7");
    check_slot(3, 7'h00, "d3_of_7");
`else
    check_slot(2, 7'h3F, "d2_of_7");
    check_slot(3, 7'h3F, "d3_of_7");
`endif
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 699) == 0) begin
        RST = 1'b1;
        #2;
        RST = 1'b0;
      end
      if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 9) == 0) btn_lap = ~btn_lap;
      @(posedge CLK);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
